// File: rtl/mul_eval_pkg.sv
// mul_eval_pkg
//   Shared definitions for the approximate-multiplier fitness evaluator:
//   operand/product widths, the run-control state encoding and the legal
//   range of the candidate multiplier latency.
package mul_eval_pkg;

    localparam int OP_W        = 16;
    localparam int PROD_W      = 32;
    localparam int MUL_LAT_MAX = 3;

    // Run control: IDLE after reset, RUN while operands are streamed,
    // DRAIN while the last samples finish the pipeline, DONE when the
    // statistics are final.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eval_state_e;

    function automatic bit mul_lat_legal(input int lat);
        return (lat >= 0) && (lat <= MUL_LAT_MAX);
    endfunction

endpackage

// File: rtl/mul_error_evaluator_accum.sv
// err_stat_accum
//   Error statistics accumulator. Each valid absolute-error sample bumps the
//   sample counter, bumps the error counter when the error is nonzero, tracks
//   the largest error and adds the error into a saturating sum.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   clear           - synchronous clear of every statistic (start of a run)
//   diff_valid      - diff carries a sample this cycle
//   diff            - absolute error of the sample
//   sample_count    - samples accumulated
//   err_count       - samples with nonzero error
//   max_err         - largest absolute error seen
//   sae             - saturating sum of absolute errors
module err_stat_accum
    import mul_eval_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              diff_valid,
    input  logic [PROD_W-1:0] diff,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [PROD_W-1:0] max_err,
    output logic [ACC_W-1:0]  sae
);

    // One extra bit catches the carry out of the sum; a carry means the true
    // sum no longer fits, so the accumulator pins at all ones. Once pinned,
    // any further add carries again (or adds zero), so it stays there.
    logic [ACC_W:0] sae_sum;

    assign sae_sum = {1'b0, sae} + {{(ACC_W + 1 - PROD_W){1'b0}}, diff};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= '0;
            err_count    <= '0;
            max_err      <= '0;
            sae          <= '0;
        end else if (clear) begin
            sample_count <= '0;
            err_count    <= '0;
            max_err      <= '0;
            sae          <= '0;
        end else if (diff_valid) begin
            sample_count <= sample_count + CNT_W'(1);
            if (diff != '0) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (diff > max_err) begin
                max_err <= diff;
            end
            sae <= sae_sum[ACC_W] ? '1 : sae_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/mul_error_evaluator.sv
// mul_error_evaluator
//   Fitness-evaluation harness wrapped around a 16x16 approximate multiplier
//   candidate. Operand pairs are accepted with a valid/ready handshake and
//   registered onto mul_a/mul_b. After MUL_LAT cycles the candidate product
//   is captured next to the exact product of the same operands, the absolute
//   error is formed, and the error statistics are accumulated.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - one-cycle pulse beginning a run (IDLE/DONE only)
//   num_samples         - samples in the run, latched on start
//   in_valid, in_ready  - operand handshake; in_ready ignores in_valid
//   in_a, in_b          - operands
//   mul_a, mul_b        - registered operands driven to the candidate
//   mul_p               - candidate product
//   busy                - run in progress (RUN or DRAIN)
//   done                - run complete, held until the next start
//   sample_count, err_count, max_err, sae - error statistics
module mul_error_evaluator
    import mul_eval_pkg::*;
#(
    parameter int MUL_LAT = 0,
    parameter int ACC_W   = 48,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [PROD_W-1:0] max_err,
    output logic [ACC_W-1:0]  sae
);

    if (!mul_lat_legal(MUL_LAT)) begin : g_bad_mul_lat
        $error("mul_error_evaluator: MUL_LAT must lie in 0..%0d", MUL_LAT_MAX);
    end
    if (ACC_W < PROD_W + 1 || ACC_W > 64) begin : g_bad_acc_w
        $error("mul_error_evaluator: ACC_W must lie in 33..64");
    end

    eval_state_e       state;
    logic [CNT_W-1:0]  n_target;
    logic [CNT_W-1:0]  accepted;

    // Operand delay line; stage 0 is the register seen by the candidate,
    // stage MUL_LAT lines up with the candidate's product.
    logic [OP_W-1:0]   a_dl [0:MUL_LAT];
    logic [OP_W-1:0]   b_dl [0:MUL_LAT];
    logic [MUL_LAT:0]  v_dl;

    logic              cap_valid;
    logic [PROD_W-1:0] approx_q;
    logic [PROD_W-1:0] exact_q;
    logic              diff_valid;
    logic [PROD_W-1:0] diff_q;

    logic              xfer;
    logic              last_xfer;
    logic              start_ok;
    logic              drain_done;

    assign in_ready  = (state == RUN) && (accepted < n_target);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && ((accepted + CNT_W'(1)) == n_target);
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign mul_a     = a_dl[0];
    assign mul_b     = b_dl[0];

    // The final sample is the only thing left in flight when it sits in the
    // diff register; moving to DONE on that edge makes done appear together
    // with its accumulation.
    assign drain_done = (state == DRAIN) && diff_valid && !cap_valid && (v_dl == '0);

    // Run control. Accepted samples are counted here, independently of the
    // valids travelling down the pipeline, so a last transfer and a late
    // accumulation can fall in the same cycle without interfering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_target <= '0;
            accepted <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_target <= num_samples;
                        accepted <= '0;
                        state    <= (num_samples == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        accepted <= accepted + CNT_W'(1);
                        if (last_xfer) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand registers and delay line. Stage 0 only loads on a transfer so
    // the candidate keeps seeing the last pair; deeper stages shift freely
    // because only the valid bit decides whether a stage is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= MUL_LAT; i++) begin
                a_dl[i] <= '0;
                b_dl[i] <= '0;
            end
            v_dl <= '0;
        end else begin
            v_dl[0] <= xfer;
            if (xfer) begin
                a_dl[0] <= in_a;
                b_dl[0] <= in_b;
            end
            for (int i = 1; i <= MUL_LAT; i++) begin
                a_dl[i] <= a_dl[i-1];
                b_dl[i] <= b_dl[i-1];
                v_dl[i] <= v_dl[i-1];
            end
        end
    end

    // Capture the candidate product alongside the exact product, then form
    // the unsigned distance as larger minus smaller so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid  <= 1'b0;
            approx_q   <= '0;
            exact_q    <= '0;
            diff_valid <= 1'b0;
            diff_q     <= '0;
        end else begin
            cap_valid <= v_dl[MUL_LAT];
            if (v_dl[MUL_LAT]) begin
                approx_q <= mul_p;
                exact_q  <= PROD_W'(a_dl[MUL_LAT]) * PROD_W'(b_dl[MUL_LAT]);
            end
            diff_valid <= cap_valid;
            if (cap_valid) begin
                diff_q <= (exact_q >= approx_q) ? (exact_q - approx_q)
                                                : (approx_q - exact_q);
            end
        end
    end

    err_stat_accum #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_accum (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_ok),
        .diff_valid   (diff_valid),
        .diff         (diff_q),
        .sample_count (sample_count),
        .err_count    (err_count),
        .max_err      (max_err),
        .sae          (sae)
    );

endmodule

// File: tb/tb_mul_error_evaluator.sv
// tb_mul_error_evaluator
//   Three evaluator instances share the operand stream:
//     dut0: MUL_LAT=0, ACC_W=48, combinational stub selectable by stub_mode
//     dut1: MUL_LAT=0, ACC_W=33, stub always returns 0
//     dut2: MUL_LAT=2, ACC_W=48, exact product through two registers
//   Each run starts only the selected instance. Expected statistics come
//   from a hand-computed table or from a plain-arithmetic model of the
//   absolute-error rules applied to the pairs sent.
module tb_mul_error_evaluator;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_bus;
    logic [31:0] num_samples;
    logic        in_valid;
    logic [15:0] in_a, in_b;

    logic        rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, dn0, dn1, dn2;
    logic [15:0] ma0, ma1, ma2, mb0, mb1, mb2;
    logic [31:0] mp0, mp1, mp2;
    logic [31:0] sc0, sc1, sc2, ec0, ec1, ec2, mx0, mx1, mx2;
    logic [47:0] sae0, sae2;
    logic [32:0] sae1;
    logic [31:0] p2_r1, p2_r2;

    int          stub_mode;
    int          sel;
    int          n_checks;
    int          n_fail;

    logic        cur_ready, cur_busy, cur_done;
    logic [15:0] cur_ma, cur_mb;
    logic [31:0] cur_sc, cur_ec, cur_mx;
    logic [63:0] cur_sae;

    always #5 clk = ~clk;

    // Candidate stubs
    function automatic logic [31:0] approxOf(input int s, input int mode,
                                             input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        if (s == 1) return 32'd0;
        if (s == 2) return p;
        case (mode)
            1:       return p & ~32'd1;
            2:       return a[0] ? (p ^ 32'h0000_0101) : (p + 32'(b));
            default: return p;
        endcase
    endfunction

    assign mp0 = approxOf(0, stub_mode, ma0, mb0);
    assign mp1 = approxOf(1, 0, ma1, mb1);
    always_ff @(posedge clk) begin
        p2_r1 <= 32'(ma2) * 32'(mb2);
        p2_r2 <= p2_r1;
    end
    assign mp2 = p2_r2;

    mul_error_evaluator #(.MUL_LAT(0), .ACC_W(48), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .start(start_bus[0]), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a), .in_b(in_b),
        .mul_a(ma0), .mul_b(mb0), .mul_p(mp0), .busy(bsy0), .done(dn0),
        .sample_count(sc0), .err_count(ec0), .max_err(mx0), .sae(sae0));

    mul_error_evaluator #(.MUL_LAT(0), .ACC_W(33), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .start(start_bus[1]), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
        .mul_a(ma1), .mul_b(mb1), .mul_p(mp1), .busy(bsy1), .done(dn1),
        .sample_count(sc1), .err_count(ec1), .max_err(mx1), .sae(sae1));

    mul_error_evaluator #(.MUL_LAT(2), .ACC_W(48), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst), .start(start_bus[2]), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
        .mul_a(ma2), .mul_b(mb2), .mul_p(mp2), .busy(bsy2), .done(dn2),
        .sample_count(sc2), .err_count(ec2), .max_err(mx2), .sae(sae2));

    // Observe whichever instance the current run targets
    always_comb begin
        cur_ready = rdy0; cur_busy = bsy0; cur_done = dn0;
        cur_ma = ma0; cur_mb = mb0;
        cur_sc = sc0; cur_ec = ec0; cur_mx = mx0; cur_sae = 64'(sae0);
        case (sel)
            1: begin
                cur_ready = rdy1; cur_busy = bsy1; cur_done = dn1;
                cur_ma = ma1; cur_mb = mb1;
                cur_sc = sc1; cur_ec = ec1; cur_mx = mx1; cur_sae = 64'(sae1);
            end
            2: begin
                cur_ready = rdy2; cur_busy = bsy2; cur_done = dn2;
                cur_ma = ma2; cur_mb = mb2;
                cur_sc = sc2; cur_ec = ec2; cur_mx = mx2; cur_sae = 64'(sae2);
            end
            default: ;
        endcase
    end

    typedef struct {
        int               s;
        int               mode;
        int               n;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [31:0]      exp_smp;
        logic [31:0]      exp_err;
        logic [31:0]      exp_max;
        logic [63:0]      exp_sae;
    } case_t;

    case_t       cases[4];
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: statistics of the queued pairs from the absolute-error rules
    task automatic computeExpected(input int s, output logic [63:0] e_smp,
                                   output logic [63:0] e_err, output logic [63:0] e_max,
                                   output logic [63:0] e_sae);
        longint ex, ap, d, sum, mx, cap;
        int     errs;
        cap  = (s == 1) ? ((longint'(1) << 33) - 1) : ((longint'(1) << 48) - 1);
        sum  = 0; mx = 0; errs = 0;
        foreach (qa[i]) begin
            ex = longint'(qa[i]) * longint'(qb[i]);
            ap = longint'(approxOf(s, stub_mode, qa[i], qb[i]));
            d  = ex - ap;
            if (d < 0) d = -d;
            if (d != 0) errs++;
            if (d > mx) mx = d;
            sum = sum + d;
            if (sum > cap) sum = cap;
        end
        e_smp = 64'(qa.size());
        e_err = 64'(errs);
        e_max = 64'(mx);
        e_sae = 64'(sum);
    endtask

    // Runs one evaluation on instance s with the queued pairs. glitch_at >= 0
    // pulses start (with a different count) once that many pairs are in.
    task automatic applyStimulus(input int s, input bit rand_valid, input int glitch_at);
        int          accepted, cyc, after, lat;
        bit          glitched;
        logic [15:0] last_a, last_b;
        sel      = s;
        lat      = (s == 2) ? 2 : 0;
        glitched = 1'b0;
        @(negedge clk);
        num_samples = 32'(qa.size());
        start_bus   = 3'(1 << s);
        @(negedge clk);
        start_bus = '0;
        accepted  = 0;
        cyc       = 0;
        last_a    = '0;
        last_b    = '0;
        while (accepted < qa.size() && cyc < 3000) begin
            checkOutput("in_ready_run", 64'(cur_ready), 64'(1));
            checkOutput("busy_run", 64'(cur_busy), 64'(1));
            if (accepted > 0) begin
                checkOutput("mul_a_hold", 64'(cur_ma), 64'(last_a));
                checkOutput("mul_b_hold", 64'(cur_mb), 64'(last_b));
            end
            start_bus = '0;
            if (accepted == glitch_at && !glitched) begin
                num_samples = 32'd99;
                start_bus   = 3'(1 << s);
                glitched    = 1'b1;
            end
            in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid) begin
                in_a = qa[accepted];
                in_b = qb[accepted];
            end else begin
                in_a = 16'($urandom);
                in_b = 16'($urandom);
            end
            if (in_valid && cur_ready) begin
                last_a = qa[accepted];
                last_b = qb[accepted];
                accepted++;
            end
            @(negedge clk);
            cyc++;
        end
        start_bus = '0;
        in_valid  = 1'b0;
        if (accepted < qa.size()) begin
            checkOutput("accept_timeout", 64'(accepted), 64'(qa.size()));
        end
        checkOutput("in_ready_after_last", 64'(cur_ready), 64'(0));
        checkOutput("done_before_drain", 64'(cur_done), 64'(0));
        after = 1;
        while (!cur_done && after < 40) begin
            @(negedge clk);
            after++;
        end
        if (!cur_done) begin
            checkOutput("done_timeout", 64'(cur_done), 64'(1));
        end else begin
            checkOutput("done_latency", 64'(after - 1), 64'(3 + lat));
        end
        checkOutput("busy_at_done", 64'(cur_busy), 64'(0));
    endtask

    task automatic checkStats(input string tag, input logic [63:0] e_smp,
                              input logic [63:0] e_err, input logic [63:0] e_max,
                              input logic [63:0] e_sae);
        checkOutput({tag, "_sample_count"}, 64'(cur_sc), e_smp);
        checkOutput({tag, "_err_count"}, 64'(cur_ec), e_err);
        checkOutput({tag, "_max_err"}, 64'(cur_mx), e_max);
        checkOutput({tag, "_sae"}, cur_sae, e_sae);
    endtask

    task automatic loadRandom(input int n);
        qa.delete();
        qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(16'($urandom));
            qb.push_back(16'($urandom));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] e_smp, e_err, e_max, e_sae;
        n_checks    = 0;
        n_fail      = 0;
        sel         = 0;
        stub_mode   = 0;
        rst         = 1'b1;
        start_bus   = '0;
        num_samples = '0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;

        cases[0] = '{s: 0, mode: 0, n: 4,
                     a: {16'h0000, 16'h1234, 16'hFFFF, 16'h0001},
                     b: {16'h0007, 16'h0010, 16'hFFFF, 16'h0001},
                     exp_smp: 32'd4, exp_err: 32'd0, exp_max: 32'd0, exp_sae: 64'd0};
        cases[1] = '{s: 0, mode: 1, n: 3,
                     a: {16'h0000, 16'hFFFF, 16'h0004, 16'h0003},
                     b: {16'h0000, 16'hFFFF, 16'h0004, 16'h0005},
                     exp_smp: 32'd3, exp_err: 32'd2, exp_max: 32'd1, exp_sae: 64'd2};
        cases[2] = '{s: 1, mode: 0, n: 3,
                     a: {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                     b: {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                     exp_smp: 32'd3, exp_err: 32'd3, exp_max: 32'hFFFE_0001,
                     exp_sae: 64'h1_FFFF_FFFF};
        cases[3] = '{s: 0, mode: 2, n: 4,
                     a: {16'h0000, 16'hFFFF, 16'h0005, 16'h0002},
                     b: {16'h0000, 16'h0001, 16'h0007, 16'h0003},
                     exp_smp: 32'd4, exp_err: 32'd3, exp_max: 32'd257, exp_sae: 64'd515};

        // Reset state
        #3;
        checkOutput("reset_done", 64'(dn0), 64'(0));
        checkOutput("reset_busy", 64'(bsy0), 64'(0));
        checkOutput("reset_in_ready", 64'(rdy0), 64'(0));
        checkOutput("reset_mul_a", 64'(ma0), 64'(0));
        checkStats("reset", 64'd0, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            qa.delete();
            qb.delete();
            for (int j = 0; j < cases[i].n; j++) begin
                qa.push_back(cases[i].a[j]);
                qb.push_back(cases[i].b[j]);
            end
            stub_mode = cases[i].mode;
            applyStimulus(cases[i].s, 1'b0, -1);
            checkStats($sformatf("table%0d", i), 64'(cases[i].exp_smp),
                       64'(cases[i].exp_err), 64'(cases[i].exp_max), cases[i].exp_sae);
        end

        // Random pairs, random valid, mixed over/under approximation
        stub_mode = 2;
        loadRandom(40);
        applyStimulus(0, 1'b1, -1);
        computeExpected(0, e_smp, e_err, e_max, e_sae);
        checkStats("rand_lat0", e_smp, e_err, e_max, e_sae);

        // Latency-2 exact candidate, 100 samples with random valid
        loadRandom(100);
        applyStimulus(2, 1'b1, -1);
        computeExpected(2, e_smp, e_err, e_max, e_sae);
        checkStats("rand_lat2", e_smp, e_err, e_max, e_sae);

        // Zero-length run: straight to DONE with cleared statistics
        sel = 0;
        @(negedge clk);
        num_samples = 32'd0;
        start_bus   = 3'b001;
        @(negedge clk);
        start_bus = '0;
        in_valid  = 1'b1;
        checkOutput("zero_done", 64'(cur_done), 64'(1));
        checkStats("zero", 64'd0, 64'd0, 64'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("zero_in_ready", 64'(cur_ready), 64'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Start pulse mid-run is ignored
        stub_mode = 1;
        loadRandom(6);
        applyStimulus(0, 1'b0, 3);
        computeExpected(0, e_smp, e_err, e_max, e_sae);
        checkStats("start_in_run", e_smp, e_err, e_max, e_sae);

        // Asynchronous reset while DRAIN is under way
        sel = 2;
        @(negedge clk);
        num_samples = 32'd3;
        start_bus   = 3'b100;
        @(negedge clk);
        start_bus = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 16'h0101 + 16'(i);
            in_b     = 16'h0202 + 16'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("drain_busy", 64'(cur_busy), 64'(1));
        checkOutput("drain_sample_count", 64'(cur_sc), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", 64'(cur_busy), 64'(0));
        checkOutput("async_rst_mul_a", 64'(cur_ma), 64'(0));
        checkOutput("async_rst_mul_b", 64'(cur_mb), 64'(0));
        checkStats("async_rst", 64'd0, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("no_done_after_rst", 64'(cur_done), 64'(0));
        loadRandom(5);
        applyStimulus(2, 1'b0, -1);
        computeExpected(2, e_smp, e_err, e_max, e_sae);
        checkStats("post_rst", e_smp, e_err, e_max, e_sae);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
